// File: rtl/sntrup_pkg.sv
// Shared constants and types for the sntrup inversion datapath.
package sntrup_pkg;

   localparam int unsigned P_LEN  = 757;
   localparam int unsigned IDX_W  = 11;
   localparam int unsigned DATA_W = 26;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN,
      FINISH
   } seq_state_t;

   // RAM addresses wrap modulo 2**IDX_W.
   function automatic logic [IDX_W-1:0] wrap_addr(
      input logic [IDX_W-1:0] base,
      input logic [IDX_W-1:0] offset
   );
      return base + offset;
   endfunction

endpackage

// File: rtl/seq_index_counter.sv
// ROM index register with synchronous clear, count enable and terminal-count flag.
module seq_index_counter
   import sntrup_pkg::*;
#(
   parameter int unsigned WIDTH = IDX_W,
   parameter int unsigned LAST  = P_LEN - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

   assign last = (count == WIDTH'(LAST));

endmodule

// File: rtl/mvu_init_sequencer.sv
// Copies the polynomial-constant ROM into the working RAM through a valid/ready write port.
// Optional INIT_CHECKSUM_EN adds a running sum of accepted words on port chk.
module mvu_init_sequencer
   import sntrup_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [IDX_W-1:0]  base_addr,
   output logic [IDX_W-1:0]  rom_index,
   input  logic [DATA_W-1:0] rom_data,
   output logic [IDX_W-1:0]  wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              busy,
`ifdef INIT_CHECKSUM_EN
   output logic [DATA_W-1:0] chk,
`endif
   output logic              done
);

   seq_state_t       state;
   logic [IDX_W-1:0] base;
   logic [IDX_W-1:0] idx;
   logic             idx_last;
   logic             loadable;
   logic             start_ok;
   logic             load;
   logic             accept;

   assign loadable = !wr_valid || wr_ready;
   assign start_ok = (state == IDLE) && start && !abort;
   assign load     = (state == FILL) && loadable && !abort;
   assign accept   = wr_valid && wr_ready;

   seq_index_counter #(
      .WIDTH (IDX_W),
      .LAST  (P_LEN - 1)
   ) u_idx (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (start_ok),
      .enable (load),
      .count  (idx),
      .last   (idx_last)
   );

   // ROM is combinational, so the index is presented while the word is being loaded.
   assign rom_index = (state == FILL) ? idx : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         base     <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  base  <= base_addr;
                  busy  <= 1'b1;
                  state <= FILL;
               end
            end
            FILL: begin
               if (abort) begin
                  wr_valid <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (loadable) begin
                  wr_data  <= rom_data;
                  wr_addr  <= wrap_addr(base, idx);
                  wr_valid <= 1'b1;
                  if (idx_last) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (abort) begin
                  wr_valid <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (wr_ready) begin
                  wr_valid <= 1'b0;
                  done     <= 1'b1;
                  state    <= FINISH;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               wr_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

`ifdef INIT_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk <= '0;
      end else if (start_ok) begin
         chk <= '0;
      end else if (accept) begin
         chk <= chk + wr_data;
      end
   end
`endif

endmodule

// File: tb/tb_mvu_init_sequencer.sv
// Directed bench for mvu_init_sequencer with a queue-based model of the expected RAM write stream.
module tb_mvu_init_sequencer;
   import sntrup_pkg::*;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              start     = 1'b0;
   logic              abort     = 1'b0;
   logic              wr_ready  = 1'b1;
   logic [IDX_W-1:0]  base_addr = '0;
   logic [IDX_W-1:0]  rom_index;
   logic [IDX_W-1:0]  wr_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              busy;
   logic              done;
`ifdef INIT_CHECKSUM_EN
   logic [DATA_W-1:0] chk;
`endif

   int vec = 0;
   int err = 0;

   always #5 clk = ~clk;

   // Constant ROM for v = 1.
   assign rom_data = (rom_index == '0) ? DATA_W'(1) : '0;

   mvu_init_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .rom_index (rom_index),
      .rom_data  (rom_data),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .busy      (busy),
`ifdef INIT_CHECKSUM_EN
      .chk       (chk),
`endif
      .done      (done)
   );

   typedef struct packed {
      logic [IDX_W-1:0]  addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t               exp_q[$];
   logic [IDX_W-1:0]  acc_addr[$];
   logic [DATA_W-1:0] acc_data[$];
   bit                exp_active = 1'b0;
   bit                done_due   = 1'b0;
   bit                prev_stall = 1'b0;
   bit                rand_ready = 1'b0;
   bit                checking   = 1'b0;
   logic [IDX_W-1:0]  prev_addr;
   logic [IDX_W-1:0]  prev_rom;
   logic [DATA_W-1:0] prev_data;
   int                n_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vec++;
      if (act !== req) begin
         err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected write stream: word k goes to (base+k) mod 2**IDX_W, only word 0 is nonzero.
   task automatic start_fill(input logic [IDX_W-1:0] b);
      wr_t w;
      @(posedge clk); #1;
      base_addr = b;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = ~b;
      exp_q.delete();
      for (int k = 0; k < int'(P_LEN); k++) begin
         w.addr = IDX_W'((int'(b) + k) % (1 << IDX_W));
         w.data = (k == 0) ? DATA_W'(1) : DATA_W'(0);
         exp_q.push_back(w);
      end
      acc_addr.delete();
      acc_data.delete();
      exp_active = 1'b1;
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_active = 1'b0;
      done_due   = 1'b0;
      prev_stall = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (exp_active && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      check("fill_finished", 32'(exp_active), 0);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && checking) begin
         if (prev_stall) begin
            check("stall_valid", 32'(wr_valid), 1);
            check("stall_addr", 32'(wr_addr), 32'(prev_addr));
            check("stall_data", 32'(wr_data), 32'(prev_data));
            check("stall_rom_index", 32'(rom_index), 32'(prev_rom));
         end
         check("busy", 32'(busy), 32'(exp_active));
         check("done", 32'(done), 32'(done_due));
         if (done_due) begin
            done_due   = 1'b0;
            exp_active = 1'b0;
            n_done++;
         end
         if (wr_valid) begin
            check("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0 && wr_ready) begin
               check("wr_addr", 32'(wr_addr), 32'(exp_q[0].addr));
               check("wr_data", 32'(wr_data), 32'(exp_q[0].data));
               acc_addr.push_back(wr_addr);
               acc_data.push_back(wr_data);
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) done_due = 1'b1;
            end
         end
         prev_stall = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
         prev_rom   = rom_index;
      end
   end

   initial begin
      #2_000_000;
      err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $fatal(1, "watchdog");
   end

   initial begin
      int cycles;
      int nd;
      int n;
      int sum;

      // Reset values with no clock edge seen yet.
      #1;
      check("rst_wr_valid", 32'(wr_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_rom_index", 32'(rom_index), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checking = 1'b1;

      // Full fill from base 0, with a start pulse mid-fill that must be ignored.
      nd = n_done;
      start_fill(0);
      cycles = 0;
      while (!done && cycles < 2000) begin
         start = (cycles == 100);
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0;
      check("done_latency", 32'(cycles), 758);
`ifdef INIT_CHECKSUM_EN
      check("chk_first_fill", 32'(chk), 1);
`endif
      wait_idle(10);
      @(negedge clk);
      check("full_done_count", 32'(n_done - nd), 1);
      check("full_words", 32'(acc_addr.size()), 757);
      check("full_addr0", 32'(acc_addr[0]), 0);
      check("full_data0", 32'(acc_data[0]), 1);
      check("full_addr_last", 32'(acc_addr[756]), 756);
      sum = 0;
      foreach (acc_data[i]) sum += int'(acc_data[i]);
      check("full_data_sum", 32'(sum), 1);
      check("idle_busy", 32'(busy), 0);

      // Random backpressure.
      rand_ready = 1'b1;
      nd = n_done;
      start_fill(0);
      wait_idle(8000);
      rand_ready = 1'b0;
      @(negedge clk);
      check("bp_words", 32'(acc_addr.size()), 757);
      check("bp_done_count", 32'(n_done - nd), 1);

      // Address wrap.
      start_fill(11'd2040);
      wait_idle(2000);
      check("wrap_addr0", 32'(acc_addr[0]), 2040);
      check("wrap_addr7", 32'(acc_addr[7]), 2047);
      check("wrap_addr8", 32'(acc_addr[8]), 0);
      check("wrap_addr_last", 32'(acc_addr[756]), 748);
      check("wrap_data0", 32'(acc_data[0]), 1);

      // Abort around word 300.
      nd = n_done;
      start_fill(0);
      n = 0;
      while (acc_addr.size() < 300 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_reached_300", 32'(acc_addr.size() >= 300), 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      clear_model();
      @(negedge clk);
      check("abort_wr_valid", 32'(wr_valid), 0);
      check("abort_busy", 32'(busy), 0);
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", 32'(n_done - nd), 0);

      // Start together with abort in IDLE is ignored.
      @(posedge clk); #1;
      base_addr = 11'd3;
      start     = 1'b1;
      abort     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("start_abort_busy", 32'(busy), 0);
      check("start_abort_valid", 32'(wr_valid), 0);
      repeat (5) @(posedge clk);
      #1;
      check("start_abort_quiet", 32'(wr_valid | busy), 0);

      // Reset in the middle of a fill.
      start_fill(11'd100);
      repeat (50) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_wr_valid", 32'(wr_valid), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_wr_addr", 32'(wr_addr), 0);
      check("midrst_rom_index", 32'(rom_index), 0);
      clear_model();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Recovery fill; restart clears and re-accumulates the checksum.
      start_fill(11'd7);
`ifdef INIT_CHECKSUM_EN
      check("chk_cleared", 32'(chk), 0);
`endif
      wait_idle(2000);
      check("recover_addr0", 32'(acc_addr[0]), 7);
      check("recover_words", 32'(acc_addr.size()), 757);
`ifdef INIT_CHECKSUM_EN
      check("chk_refill", 32'(chk), 1);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
